// File: rtl/demux_decoder2.sv
// demux_decoder2
//   Receive-side channel demultiplexer and per-channel word deserializer.
//   Each accepted 2-bit symbol is steered by its {sB,sA} select to one of
//   three channels, where WORD_SYMS symbols are assembled MSB-first into a
//   2*WORD_SYMS-bit word. Select 2'b11 is illegal and only bumps a
//   saturating error counter.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   in_valid  in   symbol on din/sB/sA is valid this cycle
//   sB, sA    in   channel select {sB,sA}: 0..2 -> channel, 3 -> illegal
//   din       in   2-bit symbol
//   flush     in   discard all partial words; drops this cycle's symbol
//   out0..2   out  last completed word per channel (held until the next one)
//   out_valid out  bit k pulses for one cycle when outk is updated
//   err_cnt   out  saturating count of accepted illegal-select symbols
//
// Handshake: in_valid is a one-way qualifier with no ready; every symbol
// presented with in_valid=1 and flush=0 is consumed on that rising edge.
// out_valid is a single-cycle strobe with no backpressure, so consumers must
// capture outk in the cycle its bit is high.
module demux_decoder2 #(
  parameter int WORD_SYMS = 4,
  parameter int ERR_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   sB,
  input  logic                   sA,
  input  logic [1:0]             din,
  input  logic                   flush,
  output logic [2*WORD_SYMS-1:0] out0,
  output logic [2*WORD_SYMS-1:0] out1,
  output logic [2*WORD_SYMS-1:0] out2,
  output logic [2:0]             out_valid,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int W   = 2 * WORD_SYMS;
  localparam int SRW = W - 2;
  localparam int CW  = (WORD_SYMS > 2) ? $clog2(WORD_SYMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_SYMS - 1);

  logic [1:0] sel;

  logic [SRW-1:0]   sr_q   [3];
  logic [SRW-1:0]   sr_d   [3];
  logic [CW-1:0]    cnt_q  [3];
  logic [CW-1:0]    cnt_d  [3];
  logic [W-1:0]     word_q [3];
  logic [W-1:0]     word_d [3];
  logic [2:0]       vld_q;
  logic [2:0]       vld_d;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;

  assign sel = {sB, sA};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sr_d[k]   = sr_q[k];
      cnt_d[k]  = cnt_q[k];
      word_d[k] = word_q[k];
    end
    vld_d = '0;
    err_d = err_q;

    if (flush) begin
      // Flush wins over a coincident symbol: it is neither routed nor
      // counted as an error. Completed words and err_cnt survive.
      for (int k = 0; k < 3; k++) begin
        sr_d[k]  = '0;
        cnt_d[k] = '0;
      end
    end else if (in_valid) begin
      if (sel == 2'b11) begin
        if (err_q != '1) begin
          err_d = err_q + 1'b1;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (sel == 2'(k)) begin
            if (cnt_q[k] == LAST) begin
              word_d[k] = {sr_q[k], din};
              cnt_d[k]  = '0;
              vld_d[k]  = 1'b1;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
            // Stale bits after a completion are harmless: the next word
            // shifts in WORD_SYMS-1 fresh symbols before it is emitted.
            sr_d[k] = SRW'({sr_q[k], din});
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        sr_q[k]   <= '0;
        cnt_q[k]  <= '0;
        word_q[k] <= '0;
      end
      vld_q <= '0;
      err_q <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        sr_q[k]   <= sr_d[k];
        cnt_q[k]  <= cnt_d[k];
        word_q[k] <= word_d[k];
      end
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign out0      = word_q[0];
  assign out1      = word_q[1];
  assign out2      = word_q[2];
  assign out_valid = vld_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_demux_decoder2.sv
// tb_demux_decoder2
//   Directed bench for demux_decoder2 (WORD_SYMS=4, ERR_W=8). Inputs change
//   on the falling edge; outputs are read on the falling edge, half a cycle
//   after the rising edge that produced them. A scoreboard pairs every
//   out_valid pulse with the next expected {channel, word} entry.
module tb_demux_decoder2;

  localparam int WORD_SYMS = 4;
  localparam int ERR_W     = 8;
  localparam int W         = 2 * WORD_SYMS;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             sB;
  logic             sA;
  logic [1:0]       din;
  logic             flush;
  logic [W-1:0]     out0;
  logic [W-1:0]     out1;
  logic [W-1:0]     out2;
  logic [2:0]       out_valid;
  logic [ERR_W-1:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Expected completions in order: {channel[1:0], word}.
  logic [W+1:0] exp_q[$];

  demux_decoder2 #(
    .WORD_SYMS(WORD_SYMS),
    .ERR_W    (ERR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .sB       (sB),
    .sA       (sA),
    .din      (din),
    .flush    (flush),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out_valid(out_valid),
    .err_cnt  (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sym(input logic [1:0] s, input logic [1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    {sB, sA} = s;
    din      = d;
    flush    = 1'b0;
  endtask

  task automatic flush_with(input logic [1:0] s, input logic [1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    {sB, sA} = s;
    din      = d;
    flush    = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid != 3'b000) begin
      logic [1:0]   ch;
      logic [W-1:0] w;
      case (out_valid)
        3'b001:  begin ch = 2'd0; w = out0; end
        3'b010:  begin ch = 2'd1; w = out1; end
        3'b100:  begin ch = 2'd2; w = out2; end
        default: begin ch = 2'd3; w = '0;   end
      endcase
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pulse", 32'(out_valid), 32'd0);
      end else begin
        check("sb_word", 32'({ch, w}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    sB       = 1'b0;
    sA       = 1'b0;
    din      = 2'b00;
    flush    = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_out0", 32'(out0), 32'h0);
    check("rst_out1", 32'(out1), 32'h0);
    check("rst_out2", 32'(out2), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    rst = 1'b0;

    // Test 1: ch0 word 01,10,11,00 -> 0x6C
    exp_q.push_back({2'd0, 8'h6C});
    sym(2'd0, 2'b01);
    sym(2'd0, 2'b10);
    sym(2'd0, 2'b11);
    sym(2'd0, 2'b00);
    idle();
    check("t1_valid", 32'(out_valid), 32'b001);
    check("t1_out0", 32'(out0), 32'h6C);
    check("t1_out1", 32'(out1), 32'h0);
    check("t1_out2", 32'(out2), 32'h0);
    idle();
    check("t1_valid_drop", 32'(out_valid), 32'b000);

    // Test 2: interleaved ch1/ch2
    exp_q.push_back({2'd2, 8'hFF});
    exp_q.push_back({2'd1, 8'h6D});
    sym(2'd1, 2'b01);
    sym(2'd1, 2'b10);
    sym(2'd1, 2'b11);
    for (int i = 0; i < 4; i++) sym(2'd2, 2'b11);
    sym(2'd1, 2'b01);
    check("t2_valid_ch2", 32'(out_valid), 32'b100);
    check("t2_out2", 32'(out2), 32'hFF);
    check("t2_out1_hold", 32'(out1), 32'h0);
    idle();
    check("t2_valid_ch1", 32'(out_valid), 32'b010);
    check("t2_out1", 32'(out1), 32'h6D);
    check("t2_out2_hold", 32'(out2), 32'hFF);
    check("t2_out0_hold", 32'(out0), 32'h6C);

    // Test 6: in_valid low, selects and data toggling
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_no_pulse", 32'(out_valid), 32'b000);
      in_valid = 1'b0;
      {sB, sA} = 2'($urandom_range(0, 3));
      din      = 2'($urandom_range(0, 3));
    end
    idle();
    check("t6_out0", 32'(out0), 32'h6C);
    check("t6_out1", 32'(out1), 32'h6D);
    check("t6_out2", 32'(out2), 32'hFF);
    check("t6_err", 32'(err_cnt), 32'h0);

    // Illegal select coinciding with flush is not an error
    flush_with(2'd3, 2'b01);
    idle();
    check("flush_sel11_err", 32'(err_cnt), 32'h0);

    // Test 3: 300 illegal symbols, counter saturates
    for (int i = 0; i < 10; i++) sym(2'd3, 2'($urandom_range(0, 3)));
    idle();
    check("t3_err10", 32'(err_cnt), 32'd10);
    for (int i = 0; i < 290; i++) sym(2'd3, 2'($urandom_range(0, 3)));
    idle();
    check("t3_err_sat", 32'(err_cnt), 32'd255);
    check("t3_valid", 32'(out_valid), 32'b000);
    check("t3_out0", 32'(out0), 32'h6C);
    check("t3_out1", 32'(out1), 32'h6D);
    check("t3_out2", 32'(out2), 32'hFF);

    // Test 4: flush discards a partial ch0 word
    exp_q.push_back({2'd0, 8'hAA});
    sym(2'd0, 2'b01);
    sym(2'd0, 2'b01);
    flush_with(2'd0, 2'b10);
    for (int i = 0; i < 4; i++) sym(2'd0, 2'b10);
    idle();
    check("t4_valid", 32'(out_valid), 32'b001);
    check("t4_out0", 32'(out0), 32'hAA);
    check("t4_err", 32'(err_cnt), 32'd255);
    idle();
    check("t4_valid_drop", 32'(out_valid), 32'b000);

    // Test 5: async reset mid-word on ch1
    sym(2'd1, 2'b11);
    sym(2'd1, 2'b11);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_out0", 32'(out0), 32'h0);
    check("t5_rst_out1", 32'(out1), 32'h0);
    check("t5_rst_out2", 32'(out2), 32'h0);
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_err", 32'(err_cnt), 32'h0);
    sym(2'd1, 2'b10);
    @(negedge clk);
    check("t5_rst_hold_out1", 32'(out1), 32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.push_back({2'd1, 8'h01});
    sym(2'd1, 2'b00);
    sym(2'd1, 2'b00);
    sym(2'd1, 2'b00);
    sym(2'd1, 2'b01);
    idle();
    check("t5_valid", 32'(out_valid), 32'b010);
    check("t5_out1", 32'(out1), 32'h01);
    idle();
    check("t5_valid_drop", 32'(out_valid), 32'b000);

    // ---------------- report ----------------
    idle();
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
